// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// lane-width helper, also intended for the future fetch path.
package memacc_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LBS = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic int lane_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Encodings 6 and 7 are reserved and behave like NOP.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op != OP_NOP) && (op <= OP_SB);
    endfunction

    function automatic logic is_word_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory-port and response bundle of the load/store unit.
// slave is the unit itself; master is the surrounding execute stage plus memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;
    logic                  stall;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_data, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_data, rsp_err, stall
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_extract.sv
// Picks one little-endian byte lane out of a memory word and zero- or
// sign-extends it back to the full word width.
module byte_lane_extract
    import memacc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]         rdata,
    input  logic [lane_w(DATA_W)-1:0] lane,
    input  logic                      sign_ext,
    output logic [DATA_W-1:0]         dout
);

    logic [7:0] lane_byte;

    assign lane_byte = rdata[{lane, 3'b000} +: 8];
    assign dout      = {{(DATA_W - 8){sign_ext & lane_byte[7]}}, lane_byte};

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one request at a time, handshaked memory port
// with timeout, single-cycle response pulse and a stall while busy.
module mem_access_unit
    import memacc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic CLOCK,
    input  logic CLEAR,
    mem_access_unit_if.slave bus
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = lane_w(DATA_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]       mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic [LANE_W-1:0]   req_lane;
    logic [DATA_W-1:0]   lane_ext;
    logic [DATA_W-1:0]   load_data;
    logic                leave_access;

    assign req_lane = bus.req_addr[LANE_W-1:0];

    byte_lane_extract #(.DATA_W(DATA_W)) u_extract (
        .rdata    (bus.mem_rdata),
        .lane     (lane_q),
        .sign_ext (op_q == OP_LBS),
        .dout     (lane_ext)
    );

    always_comb begin
        load_data = '0;
        case (op_q)
            OP_LW:          load_data = bus.mem_rdata;
            OP_LBU, OP_LBS: load_data = lane_ext;
            default:        load_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        lane_d       = lane_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;
        leave_access = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && is_mem_op(bus.req_op)) begin
                    op_d   = bus.req_op;
                    lane_d = req_lane;
                    cnt_d  = '0;
                    if (is_word_op(bus.req_op) && (req_lane != '0)) begin
                        // Misaligned word access never touches memory.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = is_store_op(bus.req_op);
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        mem_be_d    = is_word_op(bus.req_op) ? {NB{1'b1}} : NB'(1) << req_lane;
                        mem_wdata_d = (bus.req_op == OP_SB) ? {NB{bus.req_wdata[7:0]}}
                                                            : bus.req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the final allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = load_data;
                    leave_access = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    leave_access = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (leave_access) begin
            mem_en_d    = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
        end
    end

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_NOP;
            lane_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE) && !CLEAR;
    assign bus.stall     = (state_q != ST_IDLE);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised multi-cycle load/store unit sitting between the execute stage and data memory, replacing the single-cycle byte/word memory path of the 16-bit datapath. Accepts one request at a time, performs word or byte loads (zero- or sign-extended) and word or byte stores against a handshaked memory port, and returns a one-cycle response. It raises a stall while busy so the PC holds, and flags misaligned accesses and memory timeouts as errors.

## Interface
- DATA_W, 16, datapath word width; multiple of 8, at least 16.
- ADDR_W, 8, byte-address width.
- TIMEOUT, 15, maximum ACCESS cycles waited for mem_ack before erroring; at least 1.
- CLOCK  in  1  single clock, rising edge.
- CLEAR  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  0=NOP, 1=LW, 2=LBU (zero-ext), 3=LBS (sign-ext), 4=SW, 5=SB; 6,7 treated as NOP.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; SB uses bits [7:0].
- mem_en  out  1  memory access strobe, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (lane bits zeroed).
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  store data, byte replicated onto selected lane.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  access complete.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or timeout; qualified by rsp_valid.
- stall  out  1  high whenever state is not IDLE.

## Operation
- LANE_W = log2(DATA_W/8); lane = req_addr[LANE_W-1:0]; little-endian, lane 0 = bits [7:0].
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. Accept on req_valid && op in {1..5}. NOP ops accepted but ignored (no state change). Request fields latched at acceptance.
- Misaligned (LW/SW with lane != 0): IDLE -> RESP, rsp_err=1, no mem_en.
- Aligned: IDLE -> ACCESS. mem_en=1, mem_we=1 for SW/SB, mem_be all ones for word ops, one-hot at lane for byte ops, timeout counter cleared.
- ACCESS: outputs held stable. On mem_ack: load captures mem_rdata, extracts lane byte for LBU/LBS and extends to DATA_W; -> RESP, err=0. If counter reaches TIMEOUT-1 without ack: -> RESP, err=1. Ack in the same cycle as timeout: ack wins, err=0.
- RESP: rsp_valid=1 one cycle, then IDLE. No response backpressure.
- mem_ack outside ACCESS ignored.

## Timing
- Reset values: req_ready=0 while CLEAR asserted, 1 on first cycle after release (state IDLE); all other outputs 0; counter 0.
- CLEAR mid-ACCESS: mem_en drops asynchronously, pending request discarded, no response.
- Minimum load/store latency: accept at edge N, ACCESS in cycle N+1, ack in that cycle, rsp_valid in cycle N+2.
- Misaligned latency: rsp_valid in cycle N+1.
- Timeout: rsp_valid in cycle N+TIMEOUT+1.
- stall = ~IDLE, combinational from state; req_ready = IDLE && !CLEAR.
- Outputs registered except req_ready and stall.

## Structure
- Shared package memacc_pkg: op encoding constants, state enum, LANE_W function.
- One sub-module: byte_lane_extract (combinational: rdata, lane, signed -> extended byte) reused by future fetch path.
- Counter width = clog2(TIMEOUT+1).

## Test plan
- Reset then LW addr 0x10, ack in first ACCESS cycle, rdata 0xBEEF -> rsp_valid two cycles after accept, rsp_data 0xBEEF, err 0, stall high for two cycles.
- LBS addr 0x21 with rdata 0x80FF -> mem_be 2'b10, rsp_data 0xFF80; LBU same -> 0x0080.
- SB addr 0x31 wdata 0x00A5 -> mem_we 1, mem_be 2'b10, mem_wdata 0xA5A5, mem_addr 0x30, rsp_data 0.
- SW addr 0x05 -> no mem_en, rsp_valid next cycle with err 1.
- LW with ack never asserted, TIMEOUT=15 -> mem_en high 15 cycles, rsp_err 1; repeat with ack on 15th cycle -> err 0.
- CLEAR pulsed during ACCESS -> mem_en low immediately, no rsp_valid, req_ready high after release; DATA_W=32 rerun of LBS lane 3 -> correct sign extension.
